expr_parser: RTL and testbench

//  Upstream stage of the operator comparator. Consumes the ASCII byte stream

---
 rtl/expr_parser.sv | 190 +++++++++++++++++++
 tb/tb_expr_parser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_parser.sv
// expr_parser
//   Parses "<A><op><B><term>" expressions from an ASCII byte stream.
//   A and B are unsigned decimal numbers, op is one of + - * /, and the
//   terminator is TERM_EQ or TERM_CR. A complete expression produces a
//   one-cycle o_ready pulse with op/operand_a/operand_b updated. A malformed
//   expression or an operand overflow produces a one-cycle o_error pulse.
//   After an error, bytes are discarded until the next terminator arrives.
//
// Ports
//   i_clk      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   i_ready    i_data valid strobe, one cycle per byte
//   i_data     received ASCII byte
//   o_ready    one-cycle pulse: op/operand_a/operand_b updated
//   op         operator character of the last good expression
//   operand_a  first operand of the last good expression
//   operand_b  second operand of the last good expression
//   o_error    one-cycle pulse on entry to the error state
//   o_busy     high while an expression or an error discard is in progress
module expr_parser #(
    parameter int unsigned WIDTH   = 16,
    parameter logic [7:0]  TERM_EQ = 8'h3D,
    parameter logic [7:0]  TERM_CR = 8'h0D
) (
    input  logic             i_clk,
    input  logic             reset_n,
    input  logic             i_ready,
    input  logic [7:0]       i_data,
    output logic             o_ready,
    output logic [7:0]       op,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             o_error,
    output logic             o_busy
);

    localparam int unsigned EW = WIDTH + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPA,
        S_OPB,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_acc_a;
    logic [WIDTH-1:0] r_acc_b;
    logic             r_b_seen;
    logic [7:0]       r_op_latch;
    logic [7:0]       r_op;
    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    logic             r_ready;
    logic             r_error;

    logic             w_is_digit;
    logic             w_is_space;
    logic             w_is_op;
    logic             w_is_term;
    logic [3:0]       w_digit;
    logic [WIDTH-1:0] w_acc_sel;
    logic [EW-1:0]    w_acc_ext;
    logic             w_overflow;

    logic             w_load_a;
    logic             w_acc_a_upd;
    logic             w_acc_b_upd;
    logic             w_latch_op;
    logic             w_complete;
    logic             w_enter_err;

    // Byte classification
    assign w_is_digit = (i_data >= 8'h30) && (i_data <= 8'h39);
    assign w_is_space = (i_data == 8'h20);
    assign w_is_op    = (i_data == 8'h2B) || (i_data == 8'h2D) ||
                        (i_data == 8'h2A) || (i_data == 8'h2F);
    assign w_is_term  = (i_data == TERM_EQ) || (i_data == TERM_CR);
    assign w_digit    = i_data[3:0];

    // Single shared multiply-add: only one accumulator is live per state.
    // Four extra bits hold acc*10+9 for any WIDTH-bit acc, so overflow is
    // simply any set bit above WIDTH.
    assign w_acc_sel  = (r_state == S_OPB) ? r_acc_b : r_acc_a;
    assign w_acc_ext  = ({4'b0000, w_acc_sel} * EW'(10)) + EW'(w_digit);
    assign w_overflow = |w_acc_ext[EW-1:WIDTH];

    // State register
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_acc_a_upd  = 1'b0;
        w_acc_b_upd  = 1'b0;
        w_latch_op   = 1'b0;
        w_complete   = 1'b0;
        if (i_ready) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_load_a     = 1'b1;
                        w_state_next = S_OPA;
                    end else if (!w_is_space) begin
                        w_state_next = S_ERR;
                    end
                end
                S_OPA: begin
                    if (w_is_digit) begin
                        if (w_overflow) w_state_next = S_ERR;
                        else            w_acc_a_upd  = 1'b1;
                    end else if (w_is_op) begin
                        w_latch_op   = 1'b1;
                        w_state_next = S_OPB;
                    end else if (!w_is_space) begin
                        w_state_next = S_ERR;
                    end
                end
                S_OPB: begin
                    if (w_is_digit) begin
                        if (w_overflow) w_state_next = S_ERR;
                        else            w_acc_b_upd  = 1'b1;
                    end else if (w_is_term && r_b_seen) begin
                        w_complete   = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (!w_is_space) begin
                        w_state_next = S_ERR;
                    end
                end
                S_ERR: begin
                    if (w_is_term) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_enter_err = (w_state_next == S_ERR) && (r_state != S_ERR);

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_b_seen    <= 1'b0;
            r_op_latch  <= '0;
            r_op        <= '0;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_ready <= w_complete;
            r_error <= w_enter_err;
            if (w_load_a)    r_acc_a <= WIDTH'(w_digit);
            if (w_acc_a_upd) r_acc_a <= w_acc_ext[WIDTH-1:0];
            if (w_latch_op) begin
                r_op_latch <= i_data;
                r_acc_b    <= '0;
                r_b_seen   <= 1'b0;
            end
            if (w_acc_b_upd) begin
                r_acc_b  <= w_acc_ext[WIDTH-1:0];
                r_b_seen <= 1'b1;
            end
            if (w_complete) begin
                r_op        <= r_op_latch;
                r_operand_a <= r_acc_a;
                r_operand_b <= r_acc_b;
            end
        end
    end

    assign o_ready   = r_ready;
    assign o_error   = r_error;
    assign op        = r_op;
    assign operand_a = r_operand_a;
    assign operand_b = r_operand_b;
    assign o_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_expr_parser.sv
// tb_expr_parser
//   Directed bench for expr_parser (WIDTH=16). Bytes are driven one per
//   cycle; outputs are sampled 1 ns after the accepting edge. A negedge
//   monitor counts o_ready/o_error pulses and any cycle with both high.
module tb_expr_parser;

    logic        i_clk;
    logic        reset_n;
    logic        i_ready;
    logic [7:0]  i_data;
    logic        o_ready;
    logic [7:0]  op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        o_error;
    logic        o_busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_ready = 0;
    int n_err   = 0;
    int n_both  = 0;

    expr_parser #(
        .WIDTH   (16),
        .TERM_EQ (8'h3D),
        .TERM_CR (8'h0D)
    ) dut (
        .i_clk     (i_clk),
        .reset_n   (reset_n),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .o_error   (o_error),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_ready) n_ready++;
        if (o_error) n_err++;
        if (o_ready && o_error) n_both++;
    end

    // Present one byte; return 1 ns after the edge that accepts it.
    task automatic drive(input logic [7:0] b);
        i_ready = 1'b1;
        i_data  = b;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle();
        i_ready = 1'b0;
        i_data  = 8'h00;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i]);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_total++;
        if ({o_ready, o_error, o_busy} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {o_ready, o_error, o_busy});
        else n_pass++;
        n_total++;
        if ({op, operand_a, operand_b} !== 40'h0)
            $display("FAIL reset_outputs: got op=%h a=%0d b=%0d want 0/0/0", op, operand_a, operand_b);
        else n_pass++;
    endtask

    task automatic test_basic();
        int r0, e0;
        r0 = n_ready; e0 = n_err;
        drive("1"); drive("2");
        n_total++;
        if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", o_busy);
        else n_pass++;
        drive("+"); drive("3"); drive("4");
        n_total++;
        if (o_ready !== 1'b0) $display("FAIL basic_early_ready: got %b want 0", o_ready);
        else n_pass++;
        drive("=");
        n_total++;
        if (o_ready !== 1'b1) $display("FAIL basic_ready_latency: got %b want 1", o_ready);
        else n_pass++;
        n_total++;
        if (op !== 8'h2B || operand_a !== 16'd12 || operand_b !== 16'd34)
            $display("FAIL basic_values: got op=%h a=%0d b=%0d want 2b/12/34", op, operand_a, operand_b);
        else n_pass++;
        idle_cycle();
        n_total++;
        if (o_ready !== 1'b0) $display("FAIL basic_ready_width: got %b want 0", o_ready);
        else n_pass++;
        idle_cycle();
        n_total++;
        if (n_ready - r0 !== 1 || n_err - e0 !== 0)
            $display("FAIL basic_pulses: got ready=%0d err=%0d want 1/0", n_ready - r0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_spaces_cr();
        int r0, e0;
        r0 = n_ready; e0 = n_err;
        send_str({" 7 * 250", 8'h0D});
        n_total++;
        if (op !== 8'h2A || operand_a !== 16'd7 || operand_b !== 16'd250)
            $display("FAIL spaces_values: got op=%h a=%0d b=%0d want 2a/7/250", op, operand_a, operand_b);
        else n_pass++;
        n_total++;
        if (n_ready - r0 !== 1 || n_err - e0 !== 0)
            $display("FAIL spaces_pulses: got ready=%0d err=%0d want 1/0", n_ready - r0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int r0, e0;
        r0 = n_ready; e0 = n_err;
        drive("6"); drive("5"); drive("5"); drive("3");
        n_total++;
        if (o_error !== 1'b0) $display("FAIL ovf_early_error: got %b want 0", o_error);
        else n_pass++;
        drive("6");
        n_total++;
        if (o_error !== 1'b1) $display("FAIL ovf_error_latency: got %b want 1", o_error);
        else n_pass++;
        drive("+");
        n_total++;
        if (o_error !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL ovf_err_hold: got err=%b busy=%b want 0/1", o_error, o_busy);
        else n_pass++;
        drive("1"); drive("=");
        n_total++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0)
            $display("FAIL ovf_resync: got busy=%b ready=%b want 0/0", o_busy, o_ready);
        else n_pass++;
        idle_cycle();
        n_total++;
        if (n_ready - r0 !== 0 || n_err - e0 !== 1)
            $display("FAIL ovf_pulses: got ready=%0d err=%0d want 0/1", n_ready - r0, n_err - e0);
        else n_pass++;
        n_total++;
        if (op !== 8'h2A || operand_a !== 16'd7 || operand_b !== 16'd250)
            $display("FAIL ovf_hold_outputs: got op=%h a=%0d b=%0d want 2a/7/250", op, operand_a, operand_b);
        else n_pass++;
        send_str("5-3=");
        n_total++;
        if (op !== 8'h2D || operand_a !== 16'd5 || operand_b !== 16'd3)
            $display("FAIL ovf_next_expr: got op=%h a=%0d b=%0d want 2d/5/3", op, operand_a, operand_b);
        else n_pass++;
        send_str("65535/1=");
        n_total++;
        if (op !== 8'h2F || operand_a !== 16'd65535 || operand_b !== 16'd1)
            $display("FAIL ovf_max_value: got op=%h a=%0d b=%0d want 2f/65535/1", op, operand_a, operand_b);
        else n_pass++;
    endtask

    task automatic test_malformed();
        string cases [4];
        int r0, e0;
        cases[0] = "+3=";
        cases[1] = "12+=";
        cases[2] = "12+3+4=";
        cases[3] = "-5=";
        for (int k = 0; k < 4; k++) begin
            r0 = n_ready; e0 = n_err;
            send_str(cases[k]);
            // A terminator that causes the error leaves the parser in its
            // discard state; one more terminator is needed to resync.
            if (k == 1) begin
                n_total++;
                if (o_busy !== 1'b1) $display("FAIL malformed_term_err_busy: got %b want 1", o_busy);
                else n_pass++;
                send_str("=");
            end
            n_total++;
            if (n_ready - r0 !== 0 || n_err - e0 !== 1 || o_busy !== 1'b0)
                $display("FAIL malformed_%0d_pulses: got ready=%0d err=%0d busy=%b want 0/1/0",
                         k, n_ready - r0, n_err - e0, o_busy);
            else n_pass++;
            n_total++;
            if (op !== 8'h2F || operand_a !== 16'd65535 || operand_b !== 16'd1)
                $display("FAIL malformed_%0d_hold: got op=%h a=%0d b=%0d want 2f/65535/1",
                         k, op, operand_a, operand_b);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int r0, e0;
        r0 = n_ready; e0 = n_err;
        drive("1"); drive("+"); drive("2"); drive("=");
        n_total++;
        if (o_ready !== 1'b1 || op !== 8'h2B || operand_a !== 16'd1 || operand_b !== 16'd2)
            $display("FAIL b2b_first: got rdy=%b op=%h a=%0d b=%0d want 1/2b/1/2", o_ready, op, operand_a, operand_b);
        else n_pass++;
        drive("3");
        n_total++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1)
            $display("FAIL b2b_restart: got rdy=%b busy=%b want 0/1", o_ready, o_busy);
        else n_pass++;
        drive("*"); drive("4"); drive("=");
        n_total++;
        if (o_ready !== 1'b1 || op !== 8'h2A || operand_a !== 16'd3 || operand_b !== 16'd4)
            $display("FAIL b2b_second: got rdy=%b op=%h a=%0d b=%0d want 1/2a/3/4", o_ready, op, operand_a, operand_b);
        else n_pass++;
        idle_cycle();
        idle_cycle();
        n_total++;
        if (n_ready - r0 !== 2 || n_err - e0 !== 0)
            $display("FAIL b2b_pulses: got ready=%0d err=%0d want 2/0", n_ready - r0, n_err - e0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive("1"); drive("2"); drive("+");
        i_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({op, operand_a, operand_b, o_busy} !== 41'h0)
            $display("FAIL rstmid_async: got op=%h a=%0d b=%0d busy=%b want 0", op, operand_a, operand_b, o_busy);
        else n_pass++;
        @(posedge i_clk);
        #1;
        reset_n = 1'b1;
        idle_cycle();
        drive("9"); drive("/"); drive("3");
        n_total++;
        if ({o_ready, op, operand_a, operand_b} !== 41'h0)
            $display("FAIL rstmid_before_done: got rdy=%b op=%h a=%0d b=%0d want 0", o_ready, op, operand_a, operand_b);
        else n_pass++;
        drive("=");
        n_total++;
        if (o_ready !== 1'b1 || op !== 8'h2F || operand_a !== 16'd9 || operand_b !== 16'd3)
            $display("FAIL rstmid_done: got rdy=%b op=%h a=%0d b=%0d want 1/2f/9/3", o_ready, op, operand_a, operand_b);
        else n_pass++;
        idle_cycle();
    endtask

    initial begin
        i_ready = 1'b0;
        i_data  = 8'h00;
        reset_n = 1'b0;
        test_reset();
        test_basic();
        test_spaces_cr();
        test_overflow();
        test_malformed();
        test_back_to_back();
        test_reset_mid();
        n_total++;
        if (n_both !== 0) $display("FAIL ready_error_overlap: got %0d want 0", n_both);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
